// File: rtl/ro_pair_counter.sv
// ro_pair_counter: RO pair edge counter producing one PUF bit; RO_PAIR_CNT_SAT_EN makes edge counters saturate
module ro_pair_counter #(
  parameter int WINDOW      = 256,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic prev_a, prev_b, edge_a, edge_b;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] scnt;
  logic [CNT_W-1:0] nxt_a, nxt_b;
  // synchronize the free-running oscillator outputs and remember the last synced level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      prev_a <= 1'b0;
      prev_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], ro_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], ro_b};
      prev_a <= sync_a[SYNC_STAGES-1];
      prev_b <= sync_b[SYNC_STAGES-1];
    end
  assign edge_a = sync_a[SYNC_STAGES-1] & ~prev_a;
  assign edge_b = sync_b[SYNC_STAGES-1] & ~prev_b;
`ifdef RO_PAIR_CNT_SAT_EN
  assign nxt_a = (edge_a && ~&cnt_a) ? cnt_a + CNT_W'(1) : cnt_a;
  assign nxt_b = (edge_b && ~&cnt_b) ? cnt_b + CNT_W'(1) : cnt_b;
`else
  assign nxt_a = cnt_a + CNT_W'(edge_a);
  assign nxt_b = cnt_b + CNT_W'(edge_b);
`endif
  // measurement sequencer: settle flushes stale synchronizer data, run counts, done publishes the bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      scnt  <= '0;
      wcnt  <= '0;
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      resp  <= 1'b0;
      tie   <= 1'b0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            cnt_a <= '0;
            cnt_b <= '0;
            resp  <= 1'b0;
            tie   <= 1'b0;
            ro_en <= 1'b1;
            busy  <= 1'b1;
            scnt  <= SW'(SYNC_STAGES);
            state <= SETTLE;
          end
        SETTLE:
          if (scnt == '0) begin
            wcnt  <= WW'(WINDOW);
            state <= RUN;
          end else
            scnt <= scnt - SW'(1);
        RUN: begin
          cnt_a <= nxt_a;
          cnt_b <= nxt_b;
          wcnt  <= wcnt - WW'(1);
          if (wcnt == WW'(1)) begin
            resp  <= nxt_a > nxt_b;
            tie   <= nxt_a == nxt_b;
            done  <= 1'b1;
            ro_en <= 1'b0;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ro_pair_counter.sv
// tb_ro_pair_counter: randomized and directed checks of ro_pair_counter against a sampled-edge model
module tb_ro_pair_counter;
  localparam int W  = 240;
  localparam int S  = 2;
  localparam int WS = 64;
  logic clk = 0, rst = 1, start = 0, ro_a = 0, ro_b = 0;
  logic start_s = 0, ro_s = 0, zero = 0;
  logic ro_en, busy, done, resp, tie;
  logic [15:0] cnt_a, cnt_b;
  logic ro_en_s, busy_s, done_s, resp_s, tie_s;
  logic [3:0] cnt_a_s, cnt_b_s;
  int tests = 0, fails = 0, cyc = 0, ph = 0, per_a = 4, per_b = 6, ph_b = 0;
  int got_a, got_b, exp_a, exp_b;
  bit same = 0, pa = 0, pb = 0;
  int cum_a [0:19999];
  int cum_b [0:19999];

  ro_pair_counter #(.WINDOW(W), .CNT_W(16), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_en(ro_en), .busy(busy), .done(done), .resp(resp), .tie(tie),
    .cnt_a(cnt_a), .cnt_b(cnt_b));

  ro_pair_counter #(.WINDOW(WS), .CNT_W(4), .SYNC_STAGES(S)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .ro_a(ro_s), .ro_b(zero),
    .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .resp(resp_s), .tie(tie_s),
    .cnt_a(cnt_a_s), .cnt_b(cnt_b_s));

  always #5 clk = ~clk;

  // oscillator waveforms change on the falling edge, well away from sampling
  always @(negedge clk) begin
    ph   <= ph + 1;
    ro_a <= (ph % per_a) < per_a / 2;
    ro_b <= same ? ((ph % per_a) < per_a / 2) : (((ph + ph_b) % per_b) < per_b / 2);
    ro_s <= ~ro_s;
  end

  // reference: cumulative count of rising edges as sampled at each clock edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pa  <= ro_a;
    pb  <= ro_b;
    if (cyc < 19999) begin
      cum_a[cyc+1] <= cum_a[cyc] + int'(ro_a & ~pa);
      cum_b[cyc+1] <= cum_b[cyc] + int'(ro_b & ~pb);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    tests++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d+-1", tag, obs, exp);
    end
  endtask

  task automatic measure(input string tag, input bit poke);
    int k, n;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    k = cyc;
    chk({tag, "_ro_en_on"}, 32'(ro_en), 1);
    chk({tag, "_busy_on"}, 32'(busy), 1);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      start = poke && (n == 60);
      @(negedge clk);
      n++;
    end
    start = 0;
    chk({tag, "_latency"}, cyc - k, S + W + 1);
    exp_a = cum_a[k+W+1] - cum_a[k+1];
    exp_b = cum_b[k+W+1] - cum_b[k+1];
    chk_near({tag, "_cnt_a"}, int'(cnt_a), exp_a);
    chk_near({tag, "_cnt_b"}, int'(cnt_b), exp_b);
    if (exp_a - exp_b > 2 || exp_b - exp_a > 2) begin
      chk({tag, "_resp"}, 32'(resp), 32'(exp_a > exp_b));
      chk({tag, "_tie"}, 32'(tie), 0);
    end else
      chk({tag, "_resp_vs_cnt"}, 32'(resp), 32'(cnt_a > cnt_b));
    chk({tag, "_ro_en_off"}, 32'(ro_en), 0);
    got_a = int'(cnt_a);
    got_b = int'(cnt_b);
    start = poke;
    @(negedge clk);
    start = 0;
    chk({tag, "_done_once"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    @(negedge clk);
    chk({tag, "_no_restart"}, 32'(busy), 0);
    chk({tag, "_hold_a"}, 32'(cnt_a), 32'(got_a));
  endtask

  initial begin
    int k, n, exp_s;
    repeat (3) @(negedge clk);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_tie", 32'(tie), 0);
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_cnt_b", 32'(cnt_b), 0);
    chk("rst_busy_s", 32'(busy_s), 0);
    rst = 0;
    repeat (10) @(negedge clk);
    measure("basic", 0);
    chk_near("basic_a60", got_a, 60);
    chk_near("basic_b40", got_b, 40);
    chk("basic_resp1", 32'(resp), 1);
    chk("basic_tie0", 32'(tie), 0);
    per_a = 6;
    per_b = 4;
    repeat (10) @(negedge clk);
    measure("swap", 0);
    chk_near("swap_a40", got_a, 40);
    chk("swap_resp0", 32'(resp), 0);
    per_a = 8;
    same  = 1;
    repeat (10) @(negedge clk);
    measure("tie", 0);
    chk("tie_equal", 32'(got_a), 32'(got_b));
    chk_near("tie_a30", got_a, 30);
    chk("tie_flag", 32'(tie), 1);
    chk("tie_resp", 32'(resp), 0);
    same  = 0;
    per_a = 5;
    per_b = 9;
    repeat (10) @(negedge clk);
    measure("poke", 1);
    for (int i = 0; i < 4; i++) begin
      per_a = $urandom_range(4, 20);
      per_b = $urandom_range(4, 20);
      ph_b  = $urandom_range(0, 19);
      repeat (5) @(negedge clk);
      measure("rand", 0);
    end
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (S + 100) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_ro_en", 32'(ro_en), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cnt_a", 32'(cnt_a), 0);
    chk("midrst_cnt_b", 32'(cnt_b), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 0);
    end
    rst = 0;
    repeat (5) @(negedge clk);
    measure("after_rst", 0);
`ifdef RO_PAIR_CNT_SAT_EN
    exp_s = 15;
`else
    exp_s = 0;
`endif
    @(negedge clk);
    start_s = 1;
    @(negedge clk);
    start_s = 0;
    k = cyc;
    n = 0;
    while (done_s !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_latency", cyc - k, S + WS + 1);
    chk("ovf_cnt_a", 32'(cnt_a_s), 32'(exp_s));
    chk("ovf_cnt_b", 32'(cnt_b_s), 0);
    chk("ovf_resp", 32'(resp_s), 32'(exp_s > 0));
    chk("ovf_tie", 32'(tie_s), 32'(exp_s == 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Downstream measurement stage for the PUF ring oscillators. It enables a pair of ring oscillators and counts the rising edges of each over a fixed clock window, then compares the two counts to produce one PUF response bit. One instance sits after each selected RO pair. Its `ro_en` output drives both oscillators' `en` inputs, and their `roout` outputs return on `ro_a` and `ro_b`.

## Interface
- `WINDOW`, 256: measurement window length in clk cycles; must be ≥1.
- `CNT_W`, 16: width of each edge counter.
- `SYNC_STAGES`, 2: flop stages in each RO-input synchronizer; must be ≥2.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `ro_a` in 1: asynchronous oscillator output A.
- `ro_b` in 1: asynchronous oscillator output B.
- `ro_en` out 1: enable to both oscillators.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `resp` out 1: response bit; 1 iff cnt_a > cnt_b.
- `tie` out 1: 1 iff cnt_a == cnt_b.
- `cnt_a` out CNT_W: edge count of A from the last measurement.
- `cnt_b` out CNT_W: edge count of B from the last measurement.

## Operation
- **Input conditioning.** Each `ro_*` input passes through a SYNC_STAGES flop synchronizer, then a 1-flop rising-edge detector (`sync & ~prev`). Only detected edges are counted. The oscillator frequency seen at `ro_*` must be below clk/2; faster inputs alias, which is accepted behaviour.
- **State machine: IDLE, SETTLE, RUN, DONE.**
- **IDLE.**
  - `ro_en`=0 and `busy`=0.
  - On `start`=1: clear `cnt_a`, `cnt_b`, `resp` and `tie`; set `ro_en`=1; load the settle counter; go to SETTLE.
- **SETTLE.**
  - Lasts SYNC_STAGES+1 cycles. `ro_en`=1.
  - Edge detections are discarded, which flushes stale synchronizer contents.
  - Then load the window counter with WINDOW and go to RUN.
- **RUN.**
  - Lasts exactly WINDOW cycles.
  - Each cycle with a detected edge on A increments `cnt_a`; likewise B increments `cnt_b`. Both counters may increment in the same cycle.
  - Then go to DONE.
- **DONE.**
  - Lasts 1 cycle: `ro_en`=0, `done`=1.
  - `resp` and `tie` are updated from the final counts at entry.
  - Returns to IDLE.
- **Holding results.** `cnt_a`, `cnt_b`, `resp` and `tie` hold until the next accepted `start` or reset.
- **start handling.** `start` is ignored in SETTLE, RUN and DONE. It is not queued.
- **Comparison rule.** If `cnt_a` == `cnt_b`, then `tie`=1 and `resp`=0.
- **Counter widths.** The window counter is $clog2(WINDOW+1) bits. Edge counters are CNT_W bits; overflow behaviour is set under Configuration.
- **Reset.** An asserted `rst` forces IDLE immediately, at any point in any state, including mid-RUN. All of the following go to 0 without waiting for clk: `ro_en`, `busy`, `done`, `resp`, `tie`, `cnt_a`, `cnt_b`, and the synchronizer and edge flops. No partial result is ever reported.

## Timing
- **Reset values.** Every output is 0 after reset.
- **start accepted at edge k:**
  - `ro_en` and `busy` go high after edge k.
  - RUN spans the cycles after edges k+SYNC_STAGES+1 through k+SYNC_STAGES+WINDOW.
  - `done`, `resp`, `tie` and the final counts are valid in the cycle after edge k+SYNC_STAGES+WINDOW+1.
  - `busy` and `ro_en` fall at edge k+SYNC_STAGES+WINDOW+1.
  - IDLE is re-entered at edge k+SYNC_STAGES+WINDOW+2; the earliest next `start` is accepted at that edge.
- **Latency.** Total latency from the `start` edge to the `done` cycle is SYNC_STAGES+WINDOW+1 clocks. With defaults that is 259.
- **Counting skew.** Counting delay from a pin edge to the counter increment is SYNC_STAGES+1 cycles. This delay is identical for A and B, so the comparison has no skew.

## Configuration
- `RO_PAIR_CNT_SAT_EN`
  - Defined: each edge counter saturates at 2^CNT_W−1 and stops incrementing.
  - Undefined: edge counters wrap modulo 2^CNT_W.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset values.** Assert `rst` for 3 cycles → all outputs 0 and `busy`=0.
- **Basic comparison.** WINDOW=240, SYNC_STAGES=2. `ro_a` is a square wave of period 4 clk and `ro_b` of period 6 clk, both running before `start`. → `done` 243 cycles after the `start` edge; `cnt_a` = 60±1, `cnt_b` = 40±1, `resp`=1, `tie`=0. Swap the inputs → `resp`=0.
- **Tie.** Drive `ro_a` and `ro_b` from the same period-8 waveform, WINDOW=256 → `cnt_a` = `cnt_b` = 32, `tie`=1, `resp`=0.
- **Overflow.** CNT_W=4, WINDOW=64, `ro_a` of period 2 (32 edges).
  - With `RO_PAIR_CNT_SAT_EN` → `cnt_a`=15.
  - Without it → `cnt_a`=0 (32 mod 16).
- **start while busy.** Pulse `start` again in RUN and in DONE → no restart. `done` fires once, at the original latency.
- **Reset mid-run.** Assert `rst` 100 cycles into RUN → `ro_en`=0, all counts 0, no `done` pulse. A new `start` then completes normally with full-window counts.
